// File: rtl/mem_stage_lat_if.sv
// Handshake and result bundle between EX, the MEM stage and WB/debug observers.
interface mem_stage_lat_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] inst_in;
  logic [31:0] ao_in;
  logic [31:0] rt_in;
  logic [3:0]  op;
  logic        out_valid;
  logic [31:0] inst_out;
  logic [31:0] ao_out;
  logic [31:0] mo_out;
  logic        exc_out;
  logic        debug_we;
  logic [31:0] debug_addr;
  logic [31:0] debug_data;

  modport slave (
    input  in_valid, inst_in, ao_in, rt_in, op,
    output in_ready, out_valid, inst_out, ao_out, mo_out, exc_out,
           debug_we, debug_addr, debug_data
  );

  modport master (
    output in_valid, inst_in, ao_in, rt_in, op,
    input  in_ready, out_valid, inst_out, ao_out, mo_out, exc_out,
           debug_we, debug_addr, debug_data
  );
endinterface

// File: rtl/mem_stage_lat.sv
// MEM stage: byte/half/word loads and stores on an internal word memory, optional post-reset clear walk.
// Stores and non-mem ops complete next cycle; loads take LATENCY cycles with in_ready low while BUSY.
module mem_stage_lat #(
  parameter int ADDR_W         = 12,
  parameter int LATENCY        = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic           clk,
  input  logic           reset,
  mem_stage_lat_if.slave mif
);
  typedef enum logic [1:0] {CLEAR, IDLE, BUSY} state_t;

  localparam int         DEPTH  = 1 << ADDR_W;
  localparam logic [2:0] LAT_M1 = 3'(LATENCY - 1);
  localparam logic [3:0] OP_LW  = 4'd1, OP_LH = 4'd2, OP_LHU = 4'd3, OP_LB = 4'd4,
                         OP_LBU = 4'd5, OP_SW = 4'd6, OP_SH = 4'd7, OP_SB = 4'd8;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_idx;
  logic [2:0]        cnt;
  logic [31:0]       mem [DEPTH];

  logic [ADDR_W-1:0] widx;
  logic [1:0]        lane;
  logic              is_load, is_store, acc_word, acc_half, misal;
  logic [3:0]        be;
  logic [31:0]       rd_word, wr_data, merged, ld_val;
  logic [15:0]       rd_half;
  logic [7:0]        rd_byte;
  logic              rdy, accept, fin_now, fin_busy;

  logic [31:0]       p_inst, p_ao, p_mo;
  logic              p_exc;
  logic              ov_q, exc_q, dwe_q;
  logic [31:0]       inst_q, ao_q, mo_q, daddr_q, ddata_q;

  assign widx    = mif.ao_in[ADDR_W+1:2];
  assign lane    = mif.ao_in[1:0];
  assign rd_word = mem[widx];

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    acc_word = 1'b0;
    acc_half = 1'b0;
    be       = 4'h0;
    wr_data  = mif.rt_in;
    case (mif.op)
      OP_LW:         begin is_load = 1'b1; acc_word = 1'b1; end
      OP_LH, OP_LHU: begin is_load = 1'b1; acc_half = 1'b1; end
      OP_LB, OP_LBU: is_load = 1'b1;
      OP_SW:         begin is_store = 1'b1; acc_word = 1'b1; be = 4'hf; end
      OP_SH: begin
        is_store = 1'b1;
        acc_half = 1'b1;
        be       = lane[1] ? 4'hc : 4'h3;
        wr_data  = {2{mif.rt_in[15:0]}};
      end
      OP_SB: begin
        is_store = 1'b1;
        be       = 4'b0001 << lane;
        wr_data  = {4{mif.rt_in[7:0]}};
      end
      default: ;
    endcase
  end

  assign misal = (acc_word & (lane != 2'b00)) | (acc_half & lane[0]);

  // Load extraction and store byte-lane merge both work on the word read at accept.
  always_comb begin
    ld_val  = '0;
    rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
    rd_byte = rd_word[{lane, 3'b000} +: 8];
    case (mif.op)
      OP_LW:   ld_val = rd_word;
      OP_LH:   ld_val = {{16{rd_half[15]}}, rd_half};
      OP_LHU:  ld_val = {16'h0000, rd_half};
      OP_LB:   ld_val = {{24{rd_byte[7]}}, rd_byte};
      OP_LBU:  ld_val = {24'h000000, rd_byte};
      default: ld_val = '0;
    endcase
    if (misal) ld_val = '0;
    for (int b = 0; b < 4; b++)
      merged[8*b +: 8] = be[b] ? wr_data[8*b +: 8] : rd_word[8*b +: 8];
  end

  always_comb begin
    state_nxt = state;
    rdy       = 1'b0;
    accept    = 1'b0;
    fin_now   = 1'b0;
    fin_busy  = 1'b0;
    case (state)
      CLEAR: if (&clr_idx) state_nxt = IDLE;
      IDLE: begin
        rdy    = 1'b1;
        accept = mif.in_valid;
        if (accept) begin
          if (is_load && LATENCY > 1) state_nxt = BUSY;
          else                        fin_now   = 1'b1;
        end
      end
      BUSY: begin
        if (cnt == 3'd1) begin
          state_nxt = IDLE;
          fin_busy  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if (CLEAR_ON_RESET != 0) state <= CLEAR;
      else                     state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // No reset on the array; the gate on reset keeps a store from landing while reset is held.
  always_ff @(posedge clk) begin
    if (state == CLEAR)                               mem[clr_idx] <= '0;
    else if (accept && is_store && !misal && reset)   mem[widx]    <= merged;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clr_idx <= '0;
      cnt     <= '0;
      p_inst  <= '0;
      p_ao    <= '0;
      p_mo    <= '0;
      p_exc   <= 1'b0;
      ov_q    <= 1'b0;
      inst_q  <= '0;
      ao_q    <= '0;
      mo_q    <= '0;
      exc_q   <= 1'b0;
      dwe_q   <= 1'b0;
      daddr_q <= '0;
      ddata_q <= '0;
    end else begin
      ov_q  <= 1'b0;
      dwe_q <= 1'b0;
      if (state == CLEAR) clr_idx <= clr_idx + ADDR_W'(1);
      if (state == BUSY)  cnt     <= cnt - 3'd1;
      if (accept) begin
        p_inst <= mif.inst_in;
        p_ao   <= mif.ao_in;
        p_mo   <= ld_val;
        p_exc  <= misal;
        if (is_load) cnt <= LAT_M1;
        if (is_store && !misal) begin
          dwe_q   <= 1'b1;
          daddr_q <= {mif.ao_in[31:2], 2'b00};
          ddata_q <= merged;
        end
      end
      if (fin_now) begin
        ov_q   <= 1'b1;
        inst_q <= mif.inst_in;
        ao_q   <= mif.ao_in;
        mo_q   <= is_load ? ld_val : '0;
        exc_q  <= misal;
      end else if (fin_busy) begin
        ov_q   <= 1'b1;
        inst_q <= p_inst;
        ao_q   <= p_ao;
        mo_q   <= p_mo;
        exc_q  <= p_exc;
      end
    end
  end

  assign mif.in_ready   = rdy;
  assign mif.out_valid  = ov_q;
  assign mif.inst_out   = inst_q;
  assign mif.ao_out     = ao_q;
  assign mif.mo_out     = mo_q;
  assign mif.exc_out    = exc_q;
  assign mif.debug_we   = dwe_q;
  assign mif.debug_addr = daddr_q;
  assign mif.debug_data = ddata_q;
endmodule

// File: tb/tb_mem_stage_lat.sv
// Bench for mem_stage_lat (ADDR_W=4, LATENCY=3, clear on reset) against a byte-addressed memory model.
module tb_mem_stage_lat;
  localparam int AW  = 4;
  localparam int LAT = 3;
  localparam int NBYTES = 4 << AW;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_stage_lat_if mif ();

  mem_stage_lat #(.ADDR_W(AW), .LATENCY(LAT), .CLEAR_ON_RESET(1)) dut (
    .clk   (clk),
    .reset (reset),
    .mif   (mif)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  mbytes [NBYTES];
  logic [31:0] last_mo, last_da, last_dd;
  logic        last_exc, last_dwe;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Byte-granular reference: memory is a flat little-endian byte array, wrapping at its size.
  task automatic model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] r,
                       output logic [31:0] mo, output logic exc, output logic dwe,
                       output logic [31:0] da, output logic [31:0] dd);
    int size, base, wbase;
    logic [31:0] v;
    size = (o == 1 || o == 6) ? 4 : (o == 2 || o == 3 || o == 7) ? 2 :
           (o == 4 || o == 5 || o == 8) ? 1 : 0;
    base  = int'(a % NBYTES);
    wbase = base - (base % 4);
    mo = '0; exc = 1'b0; dwe = 1'b0; da = '0; dd = '0;
    if (size == 0) return;
    exc = (a % 32'(size)) != 0;
    if (exc) return;
    if (o <= 5) begin
      v = '0;
      for (int k = 0; k < size; k++) v = v | (32'(mbytes[base + k]) << (8 * k));
      if (o == 2 && v[15]) v = v | 32'hFFFF0000;
      if (o == 4 && v[7])  v = v | 32'hFFFFFF00;
      mo = v;
    end else begin
      for (int k = 0; k < size; k++) mbytes[base + k] = 8'(r >> (8 * k));
      dwe = 1'b1;
      da  = a - (a % 4);
      for (int k = 0; k < 4; k++) dd = dd | (32'(mbytes[wbase + k]) << (8 * k));
    end
  endtask

  // Called at a negedge; returns at the negedge of the completion cycle (or one later if gap).
  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] r, input bit gap);
    logic [31:0] e_mo, e_da, e_dd, inst;
    logic        e_exc, e_dwe;
    int          lat, w;
    inst = $urandom;
    mif.in_valid = 1'b1; mif.op = o; mif.ao_in = a; mif.rt_in = r; mif.inst_in = inst;
    w = 0;
    while (mif.in_ready !== 1'b1 && w < 64) begin @(negedge clk); w++; end
    if (w >= 64) begin
      chk("accept_timeout", 32'(mif.in_ready), 32'd1);
      mif.in_valid = 1'b0;
      return;
    end
    model(o, a, r, e_mo, e_exc, e_dwe, e_da, e_dd);
    lat = (o >= 1 && o <= 5) ? LAT : 1;
    @(posedge clk);
    for (int k = 1; k < lat; k++) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(mif.in_ready), 32'd0);
      chk("stall_out_valid", 32'(mif.out_valid), 32'd0);
    end
    @(negedge clk);
    mif.in_valid = 1'b0;
    chk("out_valid", 32'(mif.out_valid), 32'd1);
    chk("inst_out", mif.inst_out, inst);
    chk("ao_out", mif.ao_out, a);
    chk("mo_out", mif.mo_out, e_mo);
    chk("exc_out", 32'(mif.exc_out), 32'(e_exc));
    chk("debug_we", 32'(mif.debug_we), 32'(e_dwe));
    if (e_dwe) begin
      chk("debug_addr", mif.debug_addr, e_da);
      chk("debug_data", mif.debug_data, e_dd);
    end
    last_mo = mif.mo_out; last_exc = mif.exc_out; last_dwe = mif.debug_we;
    last_da = mif.debug_addr; last_dd = mif.debug_data;
    if (gap) begin
      @(negedge clk);
      chk("idle_out_valid", 32'(mif.out_valid), 32'd0);
      chk("idle_debug_we", 32'(mif.debug_we), 32'd0);
    end
  endtask

  task automatic count_clear(output int n, output int ov_seen);
    n = 0; ov_seen = 0;
    while (mif.in_ready !== 1'b1 && n < 100) begin
      if (mif.out_valid !== 1'b0) ov_seen++;
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n, ov_seen;
    mif.in_valid = 1'b0; mif.op = '0; mif.ao_in = '0; mif.rt_in = '0; mif.inst_in = '0;
    for (int i = 0; i < NBYTES; i++) mbytes[i] = 8'h00;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(mif.in_ready), 32'd0);
    chk("rst_out_valid", 32'(mif.out_valid), 32'd0);
    chk("rst_inst_out", mif.inst_out, 32'd0);
    chk("rst_ao_out", mif.ao_out, 32'd0);
    chk("rst_mo_out", mif.mo_out, 32'd0);
    chk("rst_exc_out", 32'(mif.exc_out), 32'd0);
    chk("rst_debug_we", 32'(mif.debug_we), 32'd0);
    chk("rst_debug_addr", mif.debug_addr, 32'd0);
    chk("rst_debug_data", mif.debug_data, 32'd0);

    reset = 1'b1;
    count_clear(n, ov_seen);
    chk("clear_cycles", 32'(n), 32'd16);
    chk("clear_out_valid", 32'(ov_seen), 32'd0);

    issue(4'd1, 32'h0000_0000, 32'h0, 1'b1);
    chk("lw0_after_clear", last_mo, 32'h0);
    issue(4'd1, 32'hFFFF_FF3C, 32'h0, 1'b1);
    chk("lw_hi_after_clear", last_mo, 32'h0);

    issue(4'd6, 32'h8, 32'h80FF7F01, 1'b0);
    issue(4'd4, 32'h8, 32'h0, 1'b0);
    chk("plan_lb_8", last_mo, 32'h00000001);
    issue(4'd4, 32'hB, 32'h0, 1'b0);
    chk("plan_lb_b", last_mo, 32'hFFFFFF80);
    issue(4'd5, 32'hB, 32'h0, 1'b0);
    chk("plan_lbu_b", last_mo, 32'h00000080);
    issue(4'd2, 32'hA, 32'h0, 1'b0);
    chk("plan_lh_a", last_mo, 32'hFFFF80FF);
    issue(4'd3, 32'hA, 32'h0, 1'b1);
    chk("plan_lhu_a", last_mo, 32'h000080FF);

    issue(4'd6, 32'h4, 32'h11223344, 1'b0);
    issue(4'd8, 32'h5, 32'h000000AA, 1'b1);
    chk("plan_sb_we", 32'(last_dwe), 32'd1);
    chk("plan_sb_addr", last_da, 32'h4);
    chk("plan_sb_data", last_dd, 32'h1122AA44);

    issue(4'd6, 32'h6, 32'hDEADBEEF, 1'b1);
    chk("plan_sw6_exc", 32'(last_exc), 32'd1);
    chk("plan_sw6_we", 32'(last_dwe), 32'd0);
    issue(4'd2, 32'h3, 32'h0, 1'b1);
    chk("plan_lh3_exc", 32'(last_exc), 32'd1);
    chk("plan_lh3_mo", last_mo, 32'h0);
    issue(4'd1, 32'h4, 32'h0, 1'b1);
    chk("plan_word4_kept", last_mo, 32'h1122AA44);

    issue(4'd7, 32'h12, 32'h0000BEEF, 1'b0);
    issue(4'd1, 32'h10, 32'h0, 1'b1);
    chk("st_then_ld", last_mo, 32'hBEEF0000);

    for (int i = 0; i < 300; i++)
      issue(4'($urandom_range(0, 15)), $urandom, $urandom, bit'($urandom_range(0, 1)));

    // Reset while a load is stalled in BUSY.
    mif.in_valid = 1'b1; mif.op = 4'd1; mif.ao_in = 32'h4; mif.inst_in = 32'h1234;
    @(posedge clk);
    @(negedge clk);
    mif.in_valid = 1'b0;
    chk("busy_in_ready", 32'(mif.in_ready), 32'd0);
    reset = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(mif.out_valid), 32'd0);
    chk("midrst_in_ready", 32'(mif.in_ready), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < NBYTES; i++) mbytes[i] = 8'h00;
    count_clear(n, ov_seen);
    chk("reclear_cycles", 32'(n), 32'd16);
    chk("reclear_out_valid", 32'(ov_seen), 32'd0);
    chk("post_clear_out_valid", 32'(mif.out_valid), 32'd0);
    issue(4'd1, 32'h4, 32'h0, 1'b1);
    chk("post_clear_lw4", last_mo, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
